// File: rtl/det_bcd_formatter_pkg.sv
// Shared types and defaults for the determinant-to-BCD formatter.
package det_bcd_formatter_pkg;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_DIGITS      = 10;
    localparam int DEF_DISP_DIGITS = 8;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_w(DEF_WIDTH);

    // 2'b11 is not a legal state; the FSM falls back to IDLE from it.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CONV = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/det_bcd_formatter_if.sv
// Start/Ack handshake plus result bus between the determinant engine, formatter and display muxes.
interface det_bcd_formatter_if
    import det_bcd_formatter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
);
    logic                  Start;
    logic                  Ack;
    logic [WIDTH-1:0]      Det;
    logic [4*DIGITS-1:0]   Bcd_flat;
    logic                  Neg;
    logic                  Ovf;
    logic                  Busy;
    logic                  Done;
    logic                  q_Idle;
    logic                  q_Conv;
    logic                  q_Done;

    modport master (
        output Start, Ack, Det,
        input  Bcd_flat, Neg, Ovf, Busy, Done, q_Idle, q_Conv, q_Done
    );

    modport slave (
        input  Start, Ack, Det,
        output Bcd_flat, Neg, Ovf, Busy, Done, q_Idle, q_Conv, q_Done
    );

endinterface

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_add3_digit (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/det_bcd_formatter.sv
// Sequential double-dabble: signed det -> sign flag + DIGITS-digit BCD magnitude, one bit per cycle.
module det_bcd_formatter
    import det_bcd_formatter_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DIGITS      = DEF_DIGITS,
    parameter int DISP_DIGITS = DEF_DISP_DIGITS
) (
    input  logic               Clk,
    input  logic               Reset_n,
    det_bcd_formatter_if.slave bus
);

    localparam int CW = cnt_w(WIDTH);
    localparam int BW = 4 * DIGITS;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mag_q;
    logic [BW-1:0]    bcd_q, bcd_adj, bcd_shift, bcd_out_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_q, ovf_q;
    logic             start_ok, last_shift;
    logic             busy, done, q_idle;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_add3_digit u_add3 (
            .din  (bcd_q[4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );

        always_ff @(posedge Clk)
            if (Reset_n) assert (bcd_out_q[4*g +: 4] <= 4'd9);
    end

    // Correct first, then shift: the magnitude MSB feeds the units digit.
    assign bcd_shift  = {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
    assign last_shift = (state == CONV) && (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge Clk) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        q_idle    = 1'b0;
        case (state)
            IDLE: begin
                q_idle   = 1'b1;
                start_ok = bus.Start;
                if (bus.Start) state_nxt = CONV;
            end
            CONV: begin
                busy = 1'b1;
                if (last_shift) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (bus.Ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Published result only moves on entry to DONE, so the display never shows partials.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            mag_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            bcd_out_q <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (start_ok) begin
            neg_q <= bus.Det[WIDTH-1];
            mag_q <= bus.Det[WIDTH-1] ? (~bus.Det + WIDTH'(1)) : bus.Det;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (state == CONV) begin
            bcd_q <= bcd_shift;
            mag_q <= {mag_q[WIDTH-2:0], 1'b0};
            cnt_q <= cnt_q + CW'(1);
            if (last_shift) begin
                bcd_out_q <= bcd_shift;
                ovf_q     <= |bcd_shift[BW-1:4*DISP_DIGITS];
            end
        end
    end

    assign bus.Bcd_flat = bcd_out_q;
    assign bus.Neg      = neg_q;
    assign bus.Ovf      = ovf_q;
    assign bus.Busy     = busy;
    assign bus.Done     = done;
    assign bus.q_Idle   = q_idle;
    assign bus.q_Conv   = busy;
    assign bus.q_Done   = done;

endmodule

// File: doc/det_bcd_formatter.md
Name: det_bcd_formatter

Overview:
- Downstream of the determinant engine. Takes its signed 32-bit `det` result and, on a Start pulse, converts it to a sign flag plus a 10-digit BCD magnitude.
- Uses a sequential double-dabble (shift-add-3) datapath.
- Feeds the top-level SSD muxes, so the eight displays show decimal instead of raw hex.
- Flags results whose magnitude does not fit on the 8 available digits.

Parameters:
- WIDTH, 32: width of the signed input value.
- DIGITS, 10: number of BCD digits produced. Must hold |-2^(WIDTH-1)|; 10 for WIDTH=32.
- DISP_DIGITS, 8: digits physically displayable; sets the overflow threshold.

Ports:
- Clk  in  1  system clock (sys_clk domain).
- Reset_n  in  1  synchronous, active-low reset.
- Start  in  1  single-cycle pulse; latch Det and begin conversion. Honoured only in IDLE.
- Ack  in  1  single-cycle pulse; release DONE back to IDLE.
- Det  in  WIDTH  signed two's-complement value to convert.
- Bcd_flat  out  4*DIGITS  BCD digits; digit k at [4k+3:4k], digit 0 = units.
- Neg  out  1  1 when the latched Det was negative.
- Ovf  out  1  1 when any digit at index >= DISP_DIGITS is nonzero.
- Busy  out  1  high in CONV.
- Done  out  1  high in DONE; Bcd_flat/Neg/Ovf valid.
- q_Idle, q_Conv, q_Done  out  1 each  one-hot state outputs for the LEDs.

Behaviour:
- Reset (Reset_n=0 at a Clk edge):
  - state=IDLE.
  - Bcd_flat=0, Neg=0, Ovf=0, Busy=0, Done=0, q_Idle=1.
  - Internal shift register and counter cleared.
  - Reset overrides all other inputs, including mid-CONV; any partial result is discarded.
- IDLE:
  - On Start=1, at the same edge:
    - Neg <= Det[WIDTH-1].
    - mag <= Det[WIDTH-1] ? -Det : Det, taken as WIDTH-bit unsigned, so -2^31 yields 2^31 (0x80000000).
    - BCD accumulator <= 0, cnt <= 0, state <= CONV.
  - Otherwise hold. Outputs keep the last result (0 after reset).
- CONV, one bit per cycle:
  - Each BCD digit >= 5 gets +3 (combinational).
  - Then {bcd, mag} is shifted left 1 bit; mag MSB enters bcd bit 0.
  - cnt increments. After the WIDTH-th shift (cnt == WIDTH-1 at the edge), state <= DONE.
  - Bcd_flat is updated only on entry to DONE and holds the previous result during CONV, so the display never shows partials.
  - Ovf is computed from the final digits on the same edge.
- Latency: Start sampled at edge k means Done=1 after edge k+WIDTH (32 cycles). Busy=1 for exactly WIDTH cycles.
- DONE:
  - Outputs held stable.
  - Ack=1 moves to IDLE next edge; outputs are retained.
  - Start in DONE is ignored; the result must be Acked first.
- Simultaneous events:
  - Start in CONV is ignored.
  - Ack outside DONE is ignored.
  - Start and Ack in the same cycle in DONE: Ack wins, and Start is not queued.
- Zero input: Neg=0, all digits 0. Negative zero cannot occur.
- Arithmetic: each digit stays in 0..9 after every correction. No digit ever exceeds 9 in Bcd_flat; a value >9 is an RTL error and is asserted against in simulation.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'b00, CONV=2'b01, DONE=2'b10; 2'b11 recovers to IDLE.
  - Default WIDTH, DIGITS and DISP_DIGITS constants.
  - CNT_W = clog2(WIDTH).
- One sub-module, bcd_add3_digit: combinational 4-bit in, 4-bit out (d>=5 ? d+3 : d). Instantiated DIGITS times via generate.
- The FSM, sign handling and shift register stay in the top.

Test Plan:
1. Det=0, Start -> after 32 cycles Done=1, Bcd_flat=0, Neg=0, Ovf=0; Busy high exactly 32 cycles.
2. Det=1234 -> digits 3..0 = 1,2,3,4, rest 0, Neg=0. Det=-56789 -> digits 4..0 = 5,6,7,8,9, Neg=1, Ovf=0.
3. Boundaries:
   - Det=99999999 -> Ovf=0, digits 7..0 all 9.
   - Det=100000000 -> Ovf=1, digit 8 = 1.
   - Det=-2147483648 -> Bcd_flat = 2147483648, Neg=1, Ovf=1.
4. Start pulsed again at cycle 10 of CONV with a different Det -> ignored; result matches the first Det; Done still at cycle 32.
5. Reset_n=0 at cycle 15 of CONV -> next edge IDLE, all outputs 0. A new Start then converts correctly.
6. In DONE, Start alone -> no change. Ack -> IDLE with outputs held. Start+Ack same cycle -> IDLE only, no new conversion. Then Start -> new conversion.
